// File: rtl/uart_tx.sv
// UART transmitter: start, 7/8 data bits LSB first, optional odd/even parity and a
// programmable stop length, paced by a shared 16x oversampling tick.
module uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  input  logic [3:0]      data_bits,
  input  logic [5:0]      stop_bits,
  input  logic [1:0]      parity_bits,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [5:0] TICK_LAST = 6'(SB_TICK - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e          state_q, state_d;
  logic [5:0]      tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] data_q, data_d;
  logic [3:0]      nbits_q, nbits_d;
  logic [5:0]      stop_q, stop_d;
  logic [1:0]      par_q, par_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            par_bit;

  // Parity covers only the bits actually sent (din[7] is dropped in 7-bit mode).
  always_comb begin
    logic x;
    x = 1'b0;
    for (int i = 0; i < DBIT; i++)
      if (i < int'(nbits_q)) x = x ^ data_q[i];
    par_bit = (par_q == 2'd1) ? ~x : x;
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    nbits_d = nbits_q;
    stop_d  = stop_q;
    par_d   = par_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // The done cycle itself is still IDLE, so a start there must be refused.
        if (tx_start && !done_q) begin
          state_d = START;
          tick_d  = '0;
          data_d  = din;
          nbits_d = (data_bits == 4'd7) ? 4'd7 : 4'(DBIT);
          stop_d  = (stop_bits == 6'd0) ? 6'd16 : stop_bits;
          par_d   = parity_bits;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = DATA;
            tick_d  = '0;
            bit_d   = '0;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (4'(bit_q) == nbits_q - 4'd1)
              state_d = (par_q != 2'd0) ? PARITY : STOP;
            else
              bit_d = bit_q + BW'(1);
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            state_d = STOP;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (tick_q == stop_q - 6'd1) begin
            state_d = IDLE;
            tick_d  = '0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is derived from the next state so the line changes on the same edge as the state.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      nbits_q <= '0;
      stop_q  <= '0;
      par_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      nbits_q <= nbits_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench for uart_tx: frames are predicted per s_tick from the line format
// rules, and a monitor rebuilds the per-tick line image from tx.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset, s_tick, tx_start;
  logic [7:0] din;
  logic [3:0] data_bits;
  logic [5:0] stop_bits;
  logic [1:0] parity_bits;
  logic       tx, tx_busy, tx_done_tick;

  uart_tx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .data_bits(data_bits), .stop_bits(stop_bits), .parity_bits(parity_bits),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           len;
    logic [255:0] bits;
  } frame_t;

  frame_t sb_q[$];
  int     checks = 0, errors = 0;
  int     cyc = 0;
  int     tick_per = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Line image per s_tick: start, data LSB first, optional parity, stop.
  function automatic frame_t model(input logic [7:0] d, input logic [3:0] db,
                                   input logic [5:0] sb, input logic [1:0] pb);
    frame_t f;
    int     n, st;
    logic   p;
    n  = (db == 4'd7) ? 7 : 8;
    st = (sb == 6'd0) ? 16 : int'(sb);
    p  = 1'b0;
    f.len  = 0;
    f.bits = '0;
    for (int k = 0; k < 16; k++) begin f.bits[f.len] = 1'b0; f.len++; end
    for (int i = 0; i < n; i++) begin
      p = p ^ d[i];
      for (int k = 0; k < 16; k++) begin f.bits[f.len] = d[i]; f.len++; end
    end
    if (pb != 2'd0)
      for (int k = 0; k < 16; k++) begin f.bits[f.len] = (pb == 2'd1) ? ~p : p; f.len++; end
    for (int k = 0; k < st; k++) begin f.bits[f.len] = 1'b1; f.len++; end
    return f;
  endfunction

  // Inputs change 2 time units after the rising edge; the monitor samples on the falling edge.
  initial begin
    int c;
    c = 0;
    s_tick = 1'b0;
    forever begin
      @(posedge clk); #2;
      c++;
      if (c >= tick_per) c = 0;
      s_tick = (c == 0);
    end
  end

  // Monitor: collects tx once per counted tick, closes the frame on tx_done_tick.
  bit     in_f = 1'b0;
  bit     busy_bad = 1'b0;
  frame_t got;
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_f = 1'b0;
      end else if (tx_done_tick) begin
        if (!in_f) begin
          chk_i("done_without_frame", 1, 0);
        end else begin
          in_f = 1'b0;
          chk_i("busy_low_at_done", int'(tx_busy), 0);
          chk_i("busy_in_frame", int'(busy_bad), 0);
          if (sb_q.size() == 0) begin
            chk_i("unexpected_frame", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk_i("frame_ticks", got.len, e.len);
            chk_v("frame_bits", got.bits, e.bits);
          end
        end
      end else if (in_f) begin
        if (!tx_busy) busy_bad = 1'b1;
        if (s_tick) begin
          if (got.len < 256) got.bits[got.len] = tx;
          got.len++;
        end
        if (got.len >= 256) begin
          chk_i("frame_overrun", got.len, 0);
          in_f = 1'b0;
        end
      end else if (tx == 1'b0) begin
        in_f     = 1'b1;
        got.len  = 0;
        got.bits = '0;
        busy_bad = !tx_busy;
        if (s_tick) begin got.bits[0] = 1'b0; got.len = 1; end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy || tx_done_tick) && n < 20000) begin step(); n++; end
    if (n >= 20000) chk_i("timeout_idle", n, 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!tx_done_tick && n < 20000) begin step(); n++; end
    if (n >= 20000) chk_i("timeout_done", n, 0);
    step();
  endtask

  task automatic set_cfg(input logic [7:0] d, input logic [3:0] db,
                         input logic [5:0] sb, input logic [1:0] pb);
    din = d; data_bits = db; stop_bits = sb; parity_bits = pb;
  endtask

  // One frame; inputs are scrambled after acceptance, optionally with a stray tx_start.
  task automatic send(input logic [7:0] d, input logic [3:0] db, input logic [5:0] sb,
                      input logic [1:0] pb, input bit mid);
    wait_idle();
    set_cfg(d, db, sb, pb);
    tx_start = 1'b1;
    sb_q.push_back(model(d, db, sb, pb));
    step();
    tx_start = 1'b0;
    set_cfg(8'($urandom), 4'($urandom), 6'($urandom), 2'($urandom));
    if (mid) begin
      repeat ($urandom_range(5, 40)) step();
      din = 8'($urandom);
      tx_start = 1'b1;
      step();
      tx_start = 1'b0;
    end
    wait_done();
    repeat (3) step();
  endtask

  initial begin
    int d0;
    int n;
    logic [3:0] db;
    reset = 1'b1; tx_start = 1'b0;
    set_cfg(8'h00, 4'd8, 6'd16, 2'd0);
    repeat (3) step();
    chk_i("reset_tx", int'(tx), 1);
    chk_i("reset_busy", int'(tx_busy), 0);
    chk_i("reset_done", int'(tx_done_tick), 0);
    reset = 1'b0;
    step();

    // Directed formats: 8N1, 7O2, 8E1.
    tick_per = 4;
    send(8'h55, 4'd8, 6'd16, 2'd0, 1'b0);
    send(8'hC3, 4'd7, 6'd32, 2'd1, 1'b0);
    send(8'h01, 4'd8, 6'd16, 2'd2, 1'b0);
    send(8'h03, 4'd8, 6'd16, 2'd2, 1'b0);
    send(8'h9E, 4'd8, 6'd24, 2'd3, 1'b1);
    send(8'h7F, 4'd0, 6'd0,  2'd1, 1'b1);

    // Abort in the third data bit, then start right as reset drops.
    wait_idle();
    set_cfg(8'hB6, 4'd8, 6'd16, 2'd0);
    tx_start = 1'b1;
    sb_q.push_back(model(8'hB6, 4'd8, 6'd16, 2'd0));
    step();
    tx_start = 1'b0;
    repeat (16 * 4 + 32 * 4 + 20) step();
    chk_i("busy_before_reset", int'(tx_busy), 1);
    reset = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    chk_i("abort_tx_high", int'(tx), 1);
    chk_i("abort_busy_low", int'(tx_busy), 0);
    chk_i("abort_no_done", int'(tx_done_tick), 0);
    #1;
    reset = 1'b0;
    set_cfg(8'h4D, 4'd7, 6'd20, 2'd2);
    tx_start = 1'b1;
    sb_q.push_back(model(8'h4D, 4'd7, 6'd20, 2'd2));
    @(posedge clk); #1;
    chk_i("tx_low_on_accept", int'(tx), 0);
    #1;
    tx_start = 1'b0;
    wait_done();

    // Held tx_start: two back-to-back 0xA5 frames.
    wait_idle();
    set_cfg(8'hA5, 4'd8, 6'd16, 2'd0);
    tx_start = 1'b1;
    sb_q.push_back(model(8'hA5, 4'd8, 6'd16, 2'd0));
    sb_q.push_back(model(8'hA5, 4'd8, 6'd16, 2'd0));
    step();
    n = 0;
    while (!tx_done_tick && n < 20000) begin step(); n++; end
    d0 = cyc;
    n = 0;
    while (!tx_busy && n < 100) begin step(); n++; end
    chk_i("b2b_gap", cyc - d0, 2);
    tx_start = 1'b0;
    wait_done();

    // Randomized frames and tick spacing.
    for (int it = 0; it < 14; it++) begin
      tick_per = $urandom_range(1, 4);
      case ($urandom_range(0, 3))
        0:       db = 4'd7;
        1:       db = 4'd8;
        default: db = 4'($urandom);
      endcase
      send(8'($urandom), db, ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
           2'($urandom), 1'($urandom));
    end

    repeat (50) step();
    chk_i("queue_empty", sb_q.size(), 0);
    chk_i("line_idle_high", int'(tx), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
